// File: rtl/fv_req_bank_router_pkg.sv
// Shared sizing constants, bank FSM states and the per-bank request packet
// consumed by the FV bank controllers.
package fv_req_bank_router_pkg;

  localparam int NUM_PE    = 4;
  localparam int NUM_BANKS = 4;
  localparam int NODE_ID_W = 8;
  localparam int FV_BW     = 16;
  localparam int TAG_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int BSEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic {
    BANK_IDLE = 1'b0,
    BANK_LOCK = 1'b1
  } bank_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     pe_tag;
    logic                 rd_wr;
    logic [NODE_ID_W-1:0] node_id;
    logic [FV_BW-1:0]     data;
    logic                 wr_sos;
    logic                 wr_eos;
  } bank_req_t;

  function automatic logic [TAG_W-1:0] onehot_to_idx(input logic [NUM_PE-1:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (oh[i]) onehot_to_idx = TAG_W'(i);
    end
  endfunction

endpackage

// File: rtl/fv_req_bank_router_rr_arbiter.sv
// Round-robin arbiter: scans the request vector starting at ptr and returns
// a one-hot grant for the first active requester.
module fv_req_bank_router_rr_arbiter
  import fv_req_bank_router_pkg::*;
#(
  parameter int N     = NUM_PE,
  parameter int PTR_W = TAG_W
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fv_req_bank_router.sv
// Routes Edge PE FV requests to banks by low Node_id bits with per-bank round-robin
// and per-bank write-stream locking. FV_REQ_ROUTER_PERF_EN adds conflict_cnt/proto_err.
module fv_req_bank_router
  import fv_req_bank_router_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PE-1:0]              pe_req_valid,
  input  logic [NUM_PE-1:0]              pe_req_rd_wr,
  input  logic [NUM_PE*NODE_ID_W-1:0]    pe_req_node_id,
  input  logic [NUM_PE*FV_BW-1:0]        pe_req_data,
  input  logic [NUM_PE-1:0]              pe_req_sos,
  input  logic [NUM_PE-1:0]              pe_req_eos,
  output logic [NUM_PE-1:0]              pe_req_ready,
  input  logic [NUM_BANKS-1:0]           bank_available,
  output logic [NUM_BANKS-1:0]           bank_req_valid,
  output logic [NUM_BANKS*TAG_W-1:0]     bank_req_pe_tag,
  output logic [NUM_BANKS-1:0]           bank_req_rd_wr,
  output logic [NUM_BANKS*NODE_ID_W-1:0] bank_req_node_id,
  output logic [NUM_BANKS*FV_BW-1:0]     bank_req_data,
  output logic [NUM_BANKS-1:0]           bank_req_wr_sos,
  output logic [NUM_BANKS-1:0]           bank_req_wr_eos
`ifdef FV_REQ_ROUTER_PERF_EN
  ,
  output logic [NUM_BANKS*16-1:0]        conflict_cnt,
  output logic                           proto_err
`endif
);

  logic [NUM_PE-1:0][BSEL_W-1:0]    pe_bank;
  logic [NUM_BANKS-1:0][NUM_PE-1:0] owner_mask;
  logic [NUM_BANKS-1:0][NUM_PE-1:0] bank_grant;
  logic [NUM_PE-1:0]                pe_busy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
      assign pe_bank[gi] = pe_req_node_id[gi*NODE_ID_W +: BSEL_W];
    end
  endgenerate

  // A PE that owns a locked bank may not be granted anywhere else until its eos.
  always_comb begin
    pe_busy      = '0;
    pe_req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      pe_busy      = pe_busy | owner_mask[b];
      pe_req_ready = pe_req_ready | bank_grant[b];
    end
  end

`ifdef FV_REQ_ROUTER_PERF_EN
  logic [NUM_BANKS-1:0] err_set;
  logic                 proto_err_reg;

  always_ff @(posedge clk) begin
    if (!reset) proto_err_reg <= 1'b0;
    else if (|err_set) proto_err_reg <= 1'b1;
  end
  assign proto_err = proto_err_reg;
`endif

  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      bank_state_e       state_reg, state_next;
      logic [TAG_W-1:0]  rr_ptr_reg, rr_ptr_next;
      logic [TAG_W-1:0]  owner_reg, owner_next;
      logic [TAG_W-1:0]  arb_idx, sel_idx;
      logic [NUM_PE-1:0] cand, arb_grant, grant;
      bank_req_t         q_reg;

      always_comb begin
        cand = '0;
        for (int p = 0; p < NUM_PE; p++) begin
          cand[p] = pe_req_valid[p] && (pe_bank[p] == BSEL_W'(gi));
        end
      end

      fv_req_bank_router_rr_arbiter #(.N(NUM_PE), .PTR_W(TAG_W)) u_arb (
        .req   (cand & ~pe_busy),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant)
      );

      assign arb_idx        = onehot_to_idx(arb_grant);
      assign sel_idx        = (state_reg == BANK_LOCK) ? owner_reg : arb_idx;
      assign owner_mask[gi] = (state_reg == BANK_LOCK) ? (NUM_PE'(1) << owner_reg) : '0;
      assign bank_grant[gi] = grant;

      always_comb begin
        grant       = '0;
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        if (reset && bank_available[gi]) begin
          if (state_reg == BANK_IDLE) begin
            if (|arb_grant) begin
              grant       = arb_grant;
              rr_ptr_next = (arb_idx == TAG_W'(NUM_PE-1)) ? '0 : arb_idx + 1'b1;
              if (pe_req_rd_wr[arb_idx] && pe_req_sos[arb_idx] && !pe_req_eos[arb_idx]) begin
                state_next = BANK_LOCK;
                owner_next = arb_idx;
              end
            end
          end else if (cand[owner_reg]) begin
            grant[owner_reg] = 1'b1;
            if (pe_req_eos[owner_reg]) state_next = BANK_IDLE;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          state_reg  <= BANK_IDLE;
          rr_ptr_reg <= '0;
          owner_reg  <= '0;
          q_reg      <= '0;
        end else begin
          state_reg   <= state_next;
          rr_ptr_reg  <= rr_ptr_next;
          owner_reg   <= owner_next;
          q_reg.valid <= |grant;
          // Payload fields hold their last value when nothing is granted.
          if (|grant) begin
            q_reg.pe_tag  <= sel_idx;
            q_reg.rd_wr   <= pe_req_rd_wr[sel_idx];
            q_reg.node_id <= pe_req_node_id[sel_idx*NODE_ID_W +: NODE_ID_W];
            q_reg.data    <= pe_req_data[sel_idx*FV_BW +: FV_BW];
            q_reg.wr_sos  <= pe_req_sos[sel_idx];
            q_reg.wr_eos  <= pe_req_eos[sel_idx];
          end
        end
      end

      assign bank_req_valid[gi]                       = q_reg.valid;
      assign bank_req_pe_tag[gi*TAG_W +: TAG_W]       = q_reg.pe_tag;
      assign bank_req_rd_wr[gi]                       = q_reg.rd_wr;
      assign bank_req_node_id[gi*NODE_ID_W +: NODE_ID_W] = q_reg.node_id;
      assign bank_req_data[gi*FV_BW +: FV_BW]         = q_reg.data;
      assign bank_req_wr_sos[gi]                      = q_reg.wr_sos;
      assign bank_req_wr_eos[gi]                      = q_reg.wr_eos;

`ifdef FV_REQ_ROUTER_PERF_EN
      logic [15:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!reset) cnt_reg <= '0;
        else if ((|(cand & ~grant)) && (cnt_reg != 16'hFFFF)) cnt_reg <= cnt_reg + 16'd1;
      end

      assign conflict_cnt[gi*16 +: 16] = cnt_reg;
      // A write accepted from IDLE without sos means the stream start was lost.
      assign err_set[gi] = (state_reg == BANK_IDLE) && (|grant) &&
                           pe_req_rd_wr[arb_idx] && !pe_req_sos[arb_idx];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_fv_req_bank_router.sv
// Scoreboard bench for fv_req_bank_router: stimulus pushes expected bank packets,
// a negedge monitor pops and compares whenever a bank presents a valid packet.
module tb_fv_req_bank_router;
  import fv_req_bank_router_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_PE-1:0]              pe_req_valid, pe_req_rd_wr, pe_req_sos, pe_req_eos, pe_req_ready;
  logic [NUM_PE*NODE_ID_W-1:0]    pe_req_node_id;
  logic [NUM_PE*FV_BW-1:0]        pe_req_data;
  logic [NUM_BANKS-1:0]           bank_available;
  logic [NUM_BANKS-1:0]           bank_req_valid, bank_req_rd_wr, bank_req_wr_sos, bank_req_wr_eos;
  logic [NUM_BANKS*TAG_W-1:0]     bank_req_pe_tag;
  logic [NUM_BANKS*NODE_ID_W-1:0] bank_req_node_id;
  logic [NUM_BANKS*FV_BW-1:0]     bank_req_data;

  logic [NODE_ID_W-1:0] node [NUM_PE];
  logic [FV_BW-1:0]     data [NUM_PE];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_flat
      assign pe_req_node_id[gi*NODE_ID_W +: NODE_ID_W] = node[gi];
      assign pe_req_data[gi*FV_BW +: FV_BW]            = data[gi];
    end
  endgenerate

  fv_req_bank_router dut (
    .clk              (clk),
    .reset            (reset),
    .pe_req_valid     (pe_req_valid),
    .pe_req_rd_wr     (pe_req_rd_wr),
    .pe_req_node_id   (pe_req_node_id),
    .pe_req_data      (pe_req_data),
    .pe_req_sos       (pe_req_sos),
    .pe_req_eos       (pe_req_eos),
    .pe_req_ready     (pe_req_ready),
    .bank_available   (bank_available),
    .bank_req_valid   (bank_req_valid),
    .bank_req_pe_tag  (bank_req_pe_tag),
    .bank_req_rd_wr   (bank_req_rd_wr),
    .bank_req_node_id (bank_req_node_id),
    .bank_req_data    (bank_req_data),
    .bank_req_wr_sos  (bank_req_wr_sos),
    .bank_req_wr_eos  (bank_req_wr_eos)
  );

  typedef struct {
    int                   cyc;
    int                   bank;
    int                   tag;
    logic                 rd_wr;
    logic [NODE_ID_W-1:0] node_id;
    logic [FV_BW-1:0]     data;
    logic                 sos;
    logic                 eos;
  } exp_t;

  exp_t sbq[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid bank packet must match an expectation scheduled for this cycle.
  always @(negedge clk) begin
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing bank%0d pkt: got no valid at cyc=%0d, required tag=%0d node=%h",
                 sbq[k].bank, sbq[k].cyc, sbq[k].tag, sbq[k].node_id);
        sbq.delete(k);
      end
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_req_valid[b] === 1'b1) begin
        int   idx;
        logic found;
        logic [TAG_W-1:0]     g_tag;
        logic [NODE_ID_W-1:0] g_node;
        logic [FV_BW-1:0]     g_data;
        found  = 1'b0;
        idx    = 0;
        g_tag  = bank_req_pe_tag[b*TAG_W +: TAG_W];
        g_node = bank_req_node_id[b*NODE_ID_W +: NODE_ID_W];
        g_data = bank_req_data[b*FV_BW +: FV_BW];
        for (int k = 0; k < sbq.size(); k++) begin
          if (!found && sbq[k].bank == b && sbq[k].cyc == cyc) begin
            found = 1'b1;
            idx   = k;
          end
        end
        total++;
        if (!found) begin
          bad++;
          $display("FAIL unexpected bank%0d pkt cyc=%0d: got tag=%0d node=%h, required no valid",
                   b, cyc, g_tag, g_node);
        end else begin
          if (g_tag !== TAG_W'(sbq[idx].tag) || bank_req_rd_wr[b] !== sbq[idx].rd_wr ||
              g_node !== sbq[idx].node_id || g_data !== sbq[idx].data ||
              bank_req_wr_sos[b] !== sbq[idx].sos || bank_req_wr_eos[b] !== sbq[idx].eos) begin
            bad++;
            $display("FAIL bank%0d pkt cyc=%0d: got tag=%0d rw=%b node=%h data=%h sos=%b eos=%b, required tag=%0d rw=%b node=%h data=%h sos=%b eos=%b",
                     b, cyc, g_tag, bank_req_rd_wr[b], g_node, g_data, bank_req_wr_sos[b], bank_req_wr_eos[b],
                     sbq[idx].tag, sbq[idx].rd_wr, sbq[idx].node_id, sbq[idx].data, sbq[idx].sos, sbq[idx].eos);
          end else begin
            $display("bank%0d pkt ok cyc=%0d tag=%0d rw=%b node=%h data=%h sos=%b eos=%b",
                     b, cyc, g_tag, bank_req_rd_wr[b], g_node, g_data, bank_req_wr_sos[b], bank_req_wr_eos[b]);
          end
          sbq.delete(idx);
        end
      end
    end
  end

  task automatic set_pe(input int p, input logic v, input logic w, input logic [NODE_ID_W-1:0] n,
                        input logic [FV_BW-1:0] d, input logic s, input logic e);
    pe_req_valid[p] = v;
    pe_req_rd_wr[p] = w;
    node[p]         = n;
    data[p]         = d;
    pe_req_sos[p]   = s;
    pe_req_eos[p]   = e;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NUM_PE; p++) set_pe(p, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // One cycle: check the combinational grant, schedule packets for accepted PEs.
  task automatic tick(input logic [NUM_PE-1:0] exp_ready);
    @(negedge clk);
    total++;
    if (pe_req_ready !== exp_ready) begin
      bad++;
      $display("FAIL ready cyc=%0d: got %b, required %b", cyc, pe_req_ready, exp_ready);
    end else begin
      $display("ready ok cyc=%0d ready=%b", cyc, pe_req_ready);
    end
    for (int p = 0; p < NUM_PE; p++) begin
      if (exp_ready[p]) begin
        exp_t e;
        logic [NODE_ID_W-1:0] n;
        n         = node[p];
        e.cyc     = cyc + 1;
        e.bank    = int'(n[BSEL_W-1:0]);
        e.tag     = p;
        e.rd_wr   = pe_req_rd_wr[p];
        e.node_id = n;
        e.data    = data[p];
        e.sos     = pe_req_sos[p];
        e.eos     = pe_req_eos[p];
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_phase(input int n);
    reset = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (pe_req_ready !== '0 || bank_req_valid !== '0 || bank_req_pe_tag !== '0 ||
          bank_req_rd_wr !== '0 || bank_req_node_id !== '0 || bank_req_data !== '0 ||
          bank_req_wr_sos !== '0 || bank_req_wr_eos !== '0) begin
        bad++;
        $display("FAIL reset outs cyc=%0d: got ready=%b valid=%b tag=%h node=%h data=%h, required all 0",
                 cyc, pe_req_ready, bank_req_valid, bank_req_pe_tag, bank_req_node_id, bank_req_data);
      end else begin
        $display("reset outs ok cyc=%0d", cyc);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    idle_all();
    bank_available = '1;

    // Reset: request held during reset is not accepted, then lands on bank1.
    set_pe(0, 1'b1, 1'b0, 8'h05, 16'h0005, 1'b0, 1'b0);
    reset_phase(2);
    tick(4'b0001);
    idle_all();
    tick(4'b0000);

    // Contention on bank0: round-robin PE0, PE1, PE2, PE0.
    for (int p = 0; p < 3; p++) set_pe(p, 1'b1, 1'b0, 8'h08, 16'hA000 + 16'(p), 1'b0, 1'b0);
    tick(4'b0001);
    tick(4'b0010);
    tick(4'b0100);
    tick(4'b0001);
    idle_all();

    // Stream lock on bank2: PE3 waits out PE1's stream, including a gap and a retarget.
    set_pe(1, 1'b1, 1'b1, 8'h02, 16'h1111, 1'b1, 1'b0);
    set_pe(3, 1'b1, 1'b0, 8'h06, 16'h3333, 1'b0, 1'b0);
    tick(4'b0010);
    set_pe(1, 1'b1, 1'b1, 8'h02, 16'h2222, 1'b0, 1'b0);
    tick(4'b0010);
    set_pe(1, 1'b0, 1'b1, 8'h02, 16'h2222, 1'b0, 1'b0);
    tick(4'b0000);
    set_pe(1, 1'b1, 1'b0, 8'h01, 16'h5555, 1'b0, 1'b0);
    tick(4'b0000);
    set_pe(1, 1'b1, 1'b1, 8'h02, 16'h4444, 1'b0, 1'b1);
    tick(4'b0010);
    set_pe(1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    tick(4'b1000);
    idle_all();

    // Parallel banks: all four PEs granted together.
    for (int p = 0; p < NUM_PE; p++) set_pe(p, 1'b1, 1'b0, 8'(p), 16'hB000 + 16'(p), 1'b0, 1'b0);
    tick(4'b1111);
    idle_all();
    tick(4'b0000);

    // Stall: bank3 unavailable for 4 cycles.
    bank_available = 4'b0111;
    set_pe(2, 1'b1, 1'b0, 8'h07, 16'h7777, 1'b0, 1'b0);
    repeat (4) tick(4'b0000);
    bank_available = '1;
    tick(4'b0100);
    idle_all();

    // Write without sos from IDLE is forwarded and does not lock the bank.
    set_pe(2, 1'b1, 1'b1, 8'h03, 16'hC0DE, 1'b0, 1'b0);
    tick(4'b0100);
    idle_all();
    set_pe(0, 1'b1, 1'b0, 8'h03, 16'hC001, 1'b0, 1'b0);
    tick(4'b0001);
    idle_all();

    // Reset mid-stream clears PE0's lock on bank1.
    set_pe(0, 1'b1, 1'b1, 8'h01, 16'hD001, 1'b1, 1'b0);
    tick(4'b0001);
    idle_all();
    reset_phase(1);
    set_pe(1, 1'b1, 1'b1, 8'h01, 16'hD002, 1'b1, 1'b1);
    tick(4'b0010);
    idle_all();
    tick(4'b0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d outstanding packets, required 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
